// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Request/response bundle used on all three sides of mem_arbiter. The
//   arbiter takes the slave view for CPU port A and console/IO port B, and
//   the master view toward the SRAM controller.
//
//   addr       address of the access
//   write_data data to store on a write
//   read       read request
//   write      write request (wins over read if both are high)
//   user       user/exec-mode qualifier passed through to memory
//   read_data  returned read data
//   ack        completion handshake
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int WORD_W = 36
);
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] write_data;
    logic              read;
    logic              write;
    logic              user;
    logic [WORD_W-1:0] read_data;
    logic              ack;

    modport master (
        output addr, write_data, read, write, user,
        input  read_data, ack
    );

    modport slave (
        input  addr, write_data, read, write, user,
        output read_data, ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-port arbiter placing CPU port A and console/IO port B onto a single
//   SRAM controller. A request sampled in IDLE is latched and presented to
//   memory from registers until mem ack; the winner then gets a one-cycle ack
//   (and read data on reads). The arbiter waits for memory ack to drop before
//   sampling again.
//
//   Ports:
//     clk      system clock, rising edge
//     reset    asynchronous, active-high reset
//     a        port A request/response (slave view)
//     b        port B request/response (slave view)
//     mem      SRAM controller request/response (master view)
//     grant_b  high while port B owns the SRAM controller
//
//   Build option:
//     MEM_ARB_ROUND_ROBIN_EN  defined: simultaneous requests alternate, A
//                             first after reset. Undefined: A always wins.
// -----------------------------------------------------------------------------
module mem_arbiter (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  a,
    mem_arbiter_if.slave  b,
    mem_arbiter_if.master mem,
    output logic          grant_b
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } state_t;

    state_t state;
    state_t state_next;

    logic req_a;
    logic req_b;
    logic pick_b;
    logic accept;
    logic complete;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = A was served last; reset value 0 means "B last" so A goes first.
    logic last_a;
`endif

    always_comb begin
        req_a      = a.read | a.write;
        req_b      = b.read | b.write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_b     = req_b & (~req_a | last_a);
`else
        pick_b     = req_b & ~req_a;
`endif
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        unique case (state)
            IDLE: begin
                // A still-high mem ack (left over from before reset) blocks
                // new requests until it drops.
                if (!mem.ack && (req_a || req_b)) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem.ack) begin
                    complete   = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!mem.ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem.addr       <= '0;
            mem.write_data <= '0;
            mem.read       <= 1'b0;
            mem.write      <= 1'b0;
            mem.user       <= 1'b0;
            a.read_data    <= '0;
            b.read_data    <= '0;
            a.ack          <= 1'b0;
            b.ack          <= 1'b0;
            grant_b        <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_a         <= 1'b0;
`endif
        end else begin
            a.ack <= 1'b0;
            b.ack <= 1'b0;

            if (accept) begin
                grant_b <= pick_b;
                if (pick_b) begin
                    mem.addr       <= b.addr;
                    mem.write_data <= b.write_data;
                    mem.user       <= b.user;
                    mem.write      <= b.write;
                    mem.read       <= b.read & ~b.write;
                end else begin
                    mem.addr       <= a.addr;
                    mem.write_data <= a.write_data;
                    mem.user       <= a.user;
                    mem.write      <= a.write;
                    mem.read       <= a.read & ~a.write;
                end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_a <= ~pick_b;
`endif
            end

            if (complete) begin
                mem.read  <= 1'b0;
                mem.write <= 1'b0;
                if (grant_b) begin
                    b.ack <= 1'b1;
                    if (mem.read) begin
                        b.read_data <= mem.read_data;
                    end
                end else begin
                    a.ack <= 1'b1;
                    if (mem.read) begin
                        a.read_data <= mem.read_data;
                    end
                end
            end

            if (state == RELEASE && !mem.ack) begin
                grant_b <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A behavioural SRAM responder answers
//   requests after a programmable latency; a monitor logs every transaction
//   presented to memory. Directed scenarios plus a randomized run are checked
//   against a transaction-level model (winner order, read-data registers).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic grant_b;

    always #5 clk = ~clk;

    mem_arbiter_if a_if ();
    mem_arbiter_if b_if ();
    mem_arbiter_if mem_if ();

    mem_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a_if),
        .b       (b_if),
        .mem     (mem_if),
        .grant_b (grant_b)
    );

    int compared   = 0;
    int mismatched = 0;

    // SRAM responder controls
    int          lat       = 1;
    bit          force_ack = 1'b0;
    logic [35:0] rd_val    = '0;

    // Transaction-level model state
    logic [35:0] exp_rd_a;
    logic [35:0] exp_rd_b;
    bit          model_last_a;

    // Monitor log
    typedef struct {
        logic [17:0] addr;
        logic [35:0] wdata;
        logic        rd;
        logic        wr;
        logic        user;
        logic        gb;
        int          n;
    } iss_t;

    iss_t issues[$];
    int   ncyc         = 0;
    int   a_ack_cnt    = 0;
    int   b_ack_cnt    = 0;
    int   both_ack_cnt = 0;
    int   mack_rise_n  = -1;
    int   last_ack_n   = -1;
    int   unstable_cnt = 0;

    // SRAM responder: raises ack lat cycles after a request appears, holds it
    // until the request drops.
    initial begin
        int resp_cnt;
        resp_cnt = 0;
        mem_if.ack = 1'b0;
        mem_if.read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                mem_if.ack = 1'b1;
                resp_cnt = 0;
            end else if (mem_if.ack) begin
                if (!(mem_if.read || mem_if.write)) mem_if.ack = 1'b0;
            end else if (mem_if.read || mem_if.write) begin
                resp_cnt++;
                if (resp_cnt >= lat) begin
                    mem_if.ack = 1'b1;
                    resp_cnt = 0;
                end
            end else begin
                resp_cnt = 0;
            end
            mem_if.read_data = mem_if.ack ? rd_val : ~rd_val;
        end
    end

    // Monitor: runs on every falling edge
    initial begin
        logic prev_busy;
        logic prev_mack;
        iss_t cur;
        prev_busy = 1'b0;
        prev_mack = 1'b0;
        cur = '{addr: '0, wdata: '0, rd: 1'b0, wr: 1'b0, user: 1'b0, gb: 1'b0, n: 0};
        forever begin
            @(negedge clk);
            if (a_if.ack === 1'b1) a_ack_cnt++;
            if (b_if.ack === 1'b1) b_ack_cnt++;
            if (a_if.ack === 1'b1 && b_if.ack === 1'b1) both_ack_cnt++;
            if (a_if.ack === 1'b1 || b_if.ack === 1'b1) last_ack_n = ncyc;
            if (mem_if.ack && !prev_mack) mack_rise_n = ncyc;
            if (mem_if.read === 1'b1 || mem_if.write === 1'b1) begin
                if (!prev_busy) begin
                    cur = '{addr: mem_if.addr, wdata: mem_if.write_data, rd: mem_if.read,
                            wr: mem_if.write, user: mem_if.user, gb: grant_b, n: ncyc};
                    issues.push_back(cur);
                end else if (mem_if.addr !== cur.addr || mem_if.write_data !== cur.wdata ||
                             mem_if.read !== cur.rd || mem_if.write !== cur.wr ||
                             mem_if.user !== cur.user || grant_b !== cur.gb) begin
                    unstable_cnt++;
                end
                prev_busy = 1'b1;
            end else begin
                prev_busy = 1'b0;
            end
            prev_mack = mem_if.ack;
            ncyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 ns");
        $fatal(1);
    end

    function automatic logic [35:0] rand36();
        return {4'($urandom_range(0, 15)), 32'($urandom)};
    endfunction

    task automatic drive(input bit is_b, input bit rd, input bit wr,
                         input logic [17:0] ad, input logic [35:0] wd, input bit us);
        if (is_b) begin
            b_if.read = rd; b_if.write = wr; b_if.addr = ad; b_if.write_data = wd; b_if.user = us;
        end else begin
            a_if.read = rd; a_if.write = wr; a_if.addr = ad; a_if.write_data = wd; a_if.user = us;
        end
    endtask

    task automatic do_reset();
        force_ack = 1'b0;
        drive(0, 0, 0, '0, '0, 0);
        drive(1, 0, 0, '0, '0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_rd_a = '0;
        exp_rd_b = '0;
        model_last_a = 1'b0;
    endtask

    // Waits for either port ack, bounded; returns with both flags low on timeout.
    task automatic wait_ack(input int limit, output bit got_a, output bit got_b);
        got_a = 1'b0;
        got_b = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (a_if.ack === 1'b1 || b_if.ack === 1'b1) begin
                got_a = a_if.ack;
                got_b = b_if.ack;
                #1;
                return;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 1, 0, 18'($urandom), rand36(), 1);
        drive(1, 0, 1, 18'($urandom), rand36(), 1);
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({mem_if.read, mem_if.write, mem_if.user, a_if.ack, b_if.ack, grant_b} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {mem_if.read, mem_if.write, mem_if.user, a_if.ack, b_if.ack, grant_b});
        end
        compared++;
        if (mem_if.addr !== 18'd0 || mem_if.write_data !== 36'd0) begin
            mismatched++;
            $display("FAIL reset_bus: got addr %h data %h want 0", mem_if.addr, mem_if.write_data);
        end
        compared++;
        if (a_if.read_data !== 36'd0 || b_if.read_data !== 36'd0) begin
            mismatched++;
            $display("FAIL reset_rdata: got a %h b %h want 0", a_if.read_data, b_if.read_data);
        end
        // Requests held while reset stays high must not start anything
        repeat (3) @(negedge clk);
        compared++;
        if ({mem_if.read, mem_if.write, a_if.ack, b_if.ack, grant_b} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_hold: got %b want 00000",
                     {mem_if.read, mem_if.write, a_if.ack, b_if.ack, grant_b});
        end
    endtask

    task automatic test_a_read();
        bit ga, gb;
        int i0, a0, b0, start_n;
        do_reset();
        lat = 4;
        rd_val = 36'o123456701234;
        i0 = issues.size(); a0 = a_ack_cnt; b0 = b_ack_cnt;
        start_n = ncyc;
        drive(0, 1, 0, 18'o001000, rand36(), 0);
        wait_ack(30, ga, gb);
        compared++;
        if ({ga, gb} !== 2'b10) begin
            mismatched++;
            $display("FAIL a_read_ack: got a/b %b%b want 10", ga, gb);
        end
        compared++;
        if (issues.size() != i0 + 1) begin
            mismatched++;
            $display("FAIL a_read_issue_cnt: got %0d want %0d", issues.size() - i0, 1);
        end else begin
            compared++;
            if ({issues[i0].rd, issues[i0].wr, issues[i0].user, issues[i0].gb} !== 4'b1000 ||
                issues[i0].addr !== 18'o001000) begin
                mismatched++;
                $display("FAIL a_read_req: got rd/wr/user/gb %b%b%b%b addr %o want 1000 addr 001000",
                         issues[i0].rd, issues[i0].wr, issues[i0].user, issues[i0].gb, issues[i0].addr);
            end
            compared++;
            if (issues[i0].n != start_n + 1) begin
                mismatched++;
                $display("FAIL a_read_issue_cycle: got %0d want %0d", issues[i0].n, start_n + 1);
            end
        end
        compared++;
        if (last_ack_n != mack_rise_n + 1) begin
            mismatched++;
            $display("FAIL a_read_ack_cycle: got %0d want %0d", last_ack_n, mack_rise_n + 1);
        end
        exp_rd_a = 36'o123456701234;
        compared++;
        if (a_if.read_data !== exp_rd_a) begin
            mismatched++;
            $display("FAIL a_read_data: got %o want %o", a_if.read_data, exp_rd_a);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0, 0);
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (a_ack_cnt - a0 != 1 || b_ack_cnt - b0 != 0) begin
            mismatched++;
            $display("FAIL a_read_pulse: got a %0d b %0d want a 1 b 0", a_ack_cnt - a0, b_ack_cnt - b0);
        end
    endtask

    task automatic test_b_write();
        bit ga, gb;
        int i0, b0;
        logic [35:0] v1;
        do_reset();
        lat = 2;
        v1 = rand36();
        rd_val = v1;
        drive(1, 1, 0, 18'o000123, '0, 0);
        wait_ack(30, ga, gb);
        exp_rd_b = v1;
        compared++;
        if ({ga, gb} !== 2'b01 || b_if.read_data !== exp_rd_b) begin
            mismatched++;
            $display("FAIL b_read: got ack %b%b data %o want 01 data %o", ga, gb, b_if.read_data, exp_rd_b);
        end
        @(posedge clk); #1;
        drive(1, 0, 0, '0, '0, 0);
        @(posedge clk); #1;
        lat = 5;
        rd_val = rand36();
        i0 = issues.size(); b0 = b_ack_cnt;
        drive(1, 0, 1, 18'o777777, 36'o777777000000, 1);
        wait_ack(30, ga, gb);
        compared++;
        if ({ga, gb} !== 2'b01) begin
            mismatched++;
            $display("FAIL b_write_ack: got a/b %b%b want 01", ga, gb);
        end
        compared++;
        if (issues.size() != i0 + 1) begin
            mismatched++;
            $display("FAIL b_write_issue_cnt: got %0d want 1", issues.size() - i0);
        end else begin
            compared++;
            if ({issues[i0].rd, issues[i0].wr, issues[i0].user, issues[i0].gb} !== 4'b0111 ||
                issues[i0].addr !== 18'o777777 || issues[i0].wdata !== 36'o777777000000) begin
                mismatched++;
                $display("FAIL b_write_req: got rd/wr/user/gb %b%b%b%b addr %o data %o want 0111 777777 777777000000",
                         issues[i0].rd, issues[i0].wr, issues[i0].user, issues[i0].gb,
                         issues[i0].addr, issues[i0].wdata);
            end
        end
        compared++;
        if (b_if.read_data !== exp_rd_b || a_if.read_data !== exp_rd_a) begin
            mismatched++;
            $display("FAIL b_write_rdata: got b %o a %o want b %o a %o",
                     b_if.read_data, a_if.read_data, exp_rd_b, exp_rd_a);
        end
        @(posedge clk); #1;
        drive(1, 0, 0, '0, '0, 0);
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (b_ack_cnt - b0 != 1 || grant_b !== 1'b0) begin
            mismatched++;
            $display("FAIL b_write_pulse: got pulses %0d grant_b %b want 1 0", b_ack_cnt - b0, grant_b);
        end
    endtask

    task automatic test_priority();
        bit ga, gb;
        bit want_b [2];
        int i0;
        do_reset();
        lat = 1;
        want_b[0] = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        want_b[1] = 1'b1;
`else
        want_b[1] = 1'b0;
`endif
        i0 = issues.size();
        drive(0, 1, 0, 18'o000111, '0, 0);
        drive(1, 1, 0, 18'o000222, '0, 0);
        for (int k = 0; k < 2; k++) begin
            rd_val = rand36();
            wait_ack(30, ga, gb);
            compared++;
            if (ga !== !want_b[k] || gb !== want_b[k]) begin
                mismatched++;
                $display("FAIL prio_winner%0d: got a/b %b%b want %b%b", k, ga, gb, !want_b[k], want_b[k]);
            end
            compared++;
            if (issues.size() != i0 + k + 1) begin
                mismatched++;
                $display("FAIL prio_issue_cnt%0d: got %0d want %0d", k, issues.size() - i0, k + 1);
            end else if (issues[i0 + k].gb !== want_b[k] ||
                         issues[i0 + k].addr !== (want_b[k] ? 18'o000222 : 18'o000111)) begin
                mismatched++;
                $display("FAIL prio_req%0d: got gb %b addr %o want gb %b", k,
                         issues[i0 + k].gb, issues[i0 + k].addr, want_b[k]);
            end
            @(posedge clk); #1;
        end
        drive(0, 0, 0, '0, '0, 0);
        drive(1, 0, 0, '0, '0, 0);
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (issues.size() != i0 + 2) begin
            mismatched++;
            $display("FAIL prio_extra_issue: got %0d want 2", issues.size() - i0);
        end
    endtask

    task automatic test_both_ops();
        bit ga, gb;
        int i0;
        do_reset();
        lat = 3;
        rd_val = rand36();
        i0 = issues.size();
        drive(0, 1, 1, 18'o070707, 36'o1234, 0);
        wait_ack(30, ga, gb);
        compared++;
        if (issues.size() != i0 + 1) begin
            mismatched++;
            $display("FAIL both_ops_issue_cnt: got %0d want 1", issues.size() - i0);
        end else if (issues[i0].wr !== 1'b1 || issues[i0].rd !== 1'b0 || issues[i0].wdata !== 36'o1234) begin
            mismatched++;
            $display("FAIL both_ops_req: got wr %b rd %b data %o want wr 1 rd 0 data 1234",
                     issues[i0].wr, issues[i0].rd, issues[i0].wdata);
        end
        compared++;
        if (ga !== 1'b1 || a_if.read_data !== exp_rd_a) begin
            mismatched++;
            $display("FAIL both_ops_ack: got ack %b rdata %o want 1 rdata %o", ga, a_if.read_data, exp_rd_a);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0, 0);
    endtask

    task automatic test_withdraw();
        bit ga, gb;
        logic [35:0] v;
        do_reset();
        lat = 4;
        v = rand36();
        rd_val = v;
        drive(0, 1, 0, 18'o000444, '0, 1);
        @(posedge clk);          // IDLE samples here
        @(posedge clk); #1;      // one cycle into BUSY
        drive(0, 0, 0, '0, '0, 0);
        wait_ack(30, ga, gb);
        exp_rd_a = v;
        compared++;
        if ({ga, gb} !== 2'b10 || a_if.read_data !== exp_rd_a) begin
            mismatched++;
            $display("FAIL withdraw: got ack %b%b rdata %o want 10 rdata %o", ga, gb, a_if.read_data, exp_rd_a);
        end
    endtask

    task automatic test_reset_busy();
        bit ga, gb;
        int i0, a0;
        logic [35:0] v;
        do_reset();
        lat = 1;
        rd_val = rand36();
        drive(0, 1, 0, 18'o000555, '0, 0);
        wait_ack(30, ga, gb);
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0, 0);
        @(posedge clk); #1;
        lat = 1000;
        drive(0, 1, 0, 18'o000666, 36'o55, 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({mem_if.read, mem_if.write, mem_if.user, a_if.ack, b_if.ack, grant_b} !== 6'b0 ||
            mem_if.addr !== 18'd0 || mem_if.write_data !== 36'd0) begin
            mismatched++;
            $display("FAIL busy_reset_out: got ctl %b addr %o data %o want 0",
                     {mem_if.read, mem_if.write, mem_if.user, a_if.ack, b_if.ack, grant_b},
                     mem_if.addr, mem_if.write_data);
        end
        compared++;
        if (a_if.read_data !== 36'd0) begin
            mismatched++;
            $display("FAIL busy_reset_rdata: got %o want 0", a_if.read_data);
        end
        exp_rd_a = '0;
        exp_rd_b = '0;
        model_last_a = 1'b0;
        a0 = a_ack_cnt;
        i0 = issues.size();
        force_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        compared++;
        if (issues.size() != i0 || a_ack_cnt != a0) begin
            mismatched++;
            $display("FAIL busy_reset_wait: got issues %0d acks %0d want 0 0", issues.size() - i0, a_ack_cnt - a0);
        end
        lat = 2;
        v = rand36();
        rd_val = v;
        force_ack = 1'b0;
        wait_ack(30, ga, gb);
        exp_rd_a = v;
        compared++;
        if ({ga, gb} !== 2'b10 || issues.size() != i0 + 1 || a_if.read_data !== exp_rd_a) begin
            mismatched++;
            $display("FAIL busy_reset_resume: got ack %b%b issues %0d rdata %o want 10 1 %o",
                     ga, gb, issues.size() - i0, a_if.read_data, exp_rd_a);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0, 0);
    endtask

    task automatic test_random();
        bit ga, gb;
        bit          req [2];
        int          op [2];
        logic [17:0] ad [2];
        logic [35:0] wd [2];
        bit          us [2];
        bit          order [2];
        int          nserve, i0, a0, b0, na, nb;
        logic [35:0] v;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            int pat;
            pat = $urandom_range(1, 3);
            req[0] = pat[0];
            req[1] = pat[1];
            for (int p = 0; p < 2; p++) begin
                op[p] = $urandom_range(1, 3);
                ad[p] = 18'($urandom);
                wd[p] = rand36();
                us[p] = 1'($urandom_range(0, 1));
            end
            if (req[0] && req[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                order[0] = model_last_a;
`else
                order[0] = 1'b0;
`endif
                order[1] = !order[0];
                nserve = 2;
            end else begin
                order[0] = req[1];
                order[1] = 1'b0;
                nserve = 1;
            end
            a0 = a_ack_cnt; b0 = b_ack_cnt; na = 0; nb = 0;
            lat = $urandom_range(1, 5);
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (req[p]) drive(p[0], op[p] != 2, op[p] != 1, ad[p], wd[p], us[p]);
            end
            for (int k = 0; k < nserve; k++) begin
                bit w;
                w = order[k];
                v = rand36();
                rd_val = v;
                i0 = issues.size();
                wait_ack(40, ga, gb);
                compared++;
                if (ga !== !w || gb !== w) begin
                    mismatched++;
                    $display("FAIL rand_winner it%0d k%0d: got a/b %b%b want %b%b", it, k, ga, gb, !w, w);
                end
                compared++;
                if (issues.size() != i0 + 1) begin
                    mismatched++;
                    $display("FAIL rand_issue_cnt it%0d k%0d: got %0d want 1", it, k, issues.size() - i0);
                end else if (issues[i0].addr !== ad[w] || issues[i0].wdata !== wd[w] ||
                             issues[i0].user !== us[w] || issues[i0].gb !== w ||
                             issues[i0].rd !== (op[w] == 1) || issues[i0].wr !== (op[w] != 1)) begin
                    mismatched++;
                    $display("FAIL rand_req it%0d k%0d: got addr %o data %o u%b gb%b rd%b wr%b want addr %o data %o u%b gb%b op%0d",
                             it, k, issues[i0].addr, issues[i0].wdata, issues[i0].user, issues[i0].gb,
                             issues[i0].rd, issues[i0].wr, ad[w], wd[w], us[w], w, op[w]);
                end
                compared++;
                if (last_ack_n != mack_rise_n + 1) begin
                    mismatched++;
                    $display("FAIL rand_ack_cycle it%0d k%0d: got %0d want %0d", it, k, last_ack_n, mack_rise_n + 1);
                end
                if (op[w] == 1) begin
                    if (w) exp_rd_b = v;
                    else   exp_rd_a = v;
                end
                compared++;
                if (a_if.read_data !== exp_rd_a || b_if.read_data !== exp_rd_b) begin
                    mismatched++;
                    $display("FAIL rand_rdata it%0d k%0d: got a %o b %o want a %o b %o",
                             it, k, a_if.read_data, b_if.read_data, exp_rd_a, exp_rd_b);
                end
                if (w) nb++;
                else   na++;
                model_last_a = !w;
                @(posedge clk); #1;
                drive(w, 0, 0, '0, '0, 0);
            end
            repeat (2) @(negedge clk);
            #1;
            compared++;
            if (a_ack_cnt - a0 != na || b_ack_cnt - b0 != nb) begin
                mismatched++;
                $display("FAIL rand_pulses it%0d: got a %0d b %0d want a %0d b %0d",
                         it, a_ack_cnt - a0, b_ack_cnt - b0, na, nb);
            end
        end
        compared++;
        if (both_ack_cnt != 0 || unstable_cnt != 0) begin
            mismatched++;
            $display("FAIL global_ack_stable: got both_ack %0d unstable %0d want 0 0", both_ack_cnt, unstable_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_a_read();
        test_b_write();
        test_priority();
        test_both_ops();
        test_withdraw();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
